bin_pipe_reg: RTL and testbench

// - Elastic, multi-share pipeline register: L stages, each holding D shares of W bits, valid/ready per stage.
// - Successor of the single-stage share register: adds depth, share count, backpressure, bubble collapse, occupancy.
// - Sits between masked gadgets needing multi-cycle alignment under stalls; shares are stored and moved

---
 rtl/bin_pipe_reg_pkg.sv | 13 +
 rtl/bin_pipe_stage.sv | 38 +++
 rtl/bin_pipe_reg.sv | 72 +++++++
 tb/tb_bin_pipe_reg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_pipe_reg_pkg.sv
// Shared helpers for the elastic multi-share pipeline register.
// Share packing and occupancy sizing live here so every file agrees.
package bin_pipe_reg_pkg;

  function automatic int occ_w(input int l);
    return $clog2(l + 1);
  endfunction

  function automatic int share_lo(input int s, input int w);
    return s * w;
  endfunction

endpackage

// File: rtl/bin_pipe_stage.sv
// One elastic stage: a valid flag plus D independent share registers.
// Each share owns its own flops; nothing here mixes two shares.
import bin_pipe_reg_pkg::*;

(* keep_hierarchy = "yes", DONT_TOUCH = "yes" *)
module bin_pipe_stage #(
  parameter int W = 1,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         src_valid,
  input  logic [D*W-1:0] src_data,
  output logic         v,
  output logic [D*W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst)       v <= 1'b0;
    else if (load) v <= src_valid;
  end

  for (genvar s = 0; s < D; s++) begin : g_share
    logic [W-1:0] q;

    // Bubbles never overwrite stored shares.
    always_ff @(posedge clk) begin
      if (rst)
        q <= '0;
      else if (load && src_valid)
        q <= src_data[share_lo(s, W) +: W];
    end

    assign data[share_lo(s, W) +: W] = q;
  end

endmodule

// File: rtl/bin_pipe_reg.sv
// Elastic L-deep pipeline of D-share words with per-stage valid/ready.
// Empty stages absorb upstream words even while the output stalls.
import bin_pipe_reg_pkg::*;

(* keep_hierarchy = "yes", DONT_TOUCH = "yes" *)
module bin_pipe_reg #(
  parameter int W = 1,
  parameter int D = 2,
  parameter int L = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [D*W-1:0]      in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [D*W-1:0]      out_data,
  output logic [occ_w(L)-1:0] occupancy
);

  localparam int OW = occ_w(L);

  logic [L-1:0]   v;
  logic [L:0]     rdy;
  logic [D*W-1:0] dq [L];

  // Ready ripples from the output back toward the input.
  always_comb begin
    rdy    = '0;
    rdy[L] = out_ready;
    for (int k = L - 1; k >= 0; k--)
      rdy[k] = !v[k] || rdy[k+1];
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic           sv;
    logic [D*W-1:0] sd;

    if (k == 0) begin : g_head
      assign sv = in_valid;
      assign sd = in_data;
    end else begin : g_body
      assign sv = v[k-1];
      assign sd = dq[k-1];
    end

    bin_pipe_stage #(
      .W(W),
      .D(D)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (rdy[k]),
      .src_valid(sv),
      .src_data (sd),
      .v        (v[k]),
      .data     (dq[k])
    );
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < L; k++)
      occupancy = occupancy + OW'(v[k]);
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[L-1];
  assign out_data  = dq[L-1];

endmodule

// File: tb/tb_bin_pipe_reg.sv
// Directed and scoreboarded checks of bin_pipe_reg in three configs.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_bin_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // A: W=8 D=2 L=3
  logic        a_iv = 0, a_ir, a_ov, a_or = 0;
  logic [15:0] a_id = '0, a_od;
  logic [1:0]  a_occ;
  // B: W=4 D=3 L=2
  logic        b_iv = 0, b_ir, b_ov, b_or = 0;
  logic [11:0] b_id = '0, b_od;
  logic [1:0]  b_occ;
  // C: W=1 D=1 L=1
  logic        c_iv = 0, c_ir, c_ov, c_or = 0;
  logic [0:0]  c_id = '0, c_od;
  logic [0:0]  c_occ;

  bin_pipe_reg #(.W(8), .D(2), .L(3)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .occupancy(a_occ)
  );

  bin_pipe_reg #(.W(4), .D(3), .L(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .occupancy(b_occ)
  );

  bin_pipe_reg #(.W(1), .D(1), .L(1)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .occupancy(c_occ)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wa(input int i);
    return {8'(i + 16), 8'(i)};
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [11:0] q[$];
  logic [11:0] e;
  int occ_e;

  initial begin
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_occ", 32'(a_occ), 0);
    chk("rst_od", 32'(a_od), 0);
    chk("rst_ir", 32'(a_ir), 1);

    // Streaming, out_ready high.
    a_or = 1'b1;
    for (int c = 0; c < 9; c++) begin
      a_iv = (c < 6);
      a_id = (c < 6) ? wa(c + 1) : 16'h0;
      step();
      occ_e = 0;
      for (int k = c - 1; k <= c + 1; k++)
        if (k >= 1 && k <= 6) occ_e++;
      chk("str_occ", 32'(a_occ), 32'(occ_e));
      chk("str_ov", 32'(a_ov), 32'(c >= 2 && c <= 7));
      if (c >= 2 && c <= 7)
        chk("str_od", 32'(a_od), 32'(wa(c - 1)));
    end

    // Fill under backpressure.
    a_or = 1'b0;
    for (int j = 0; j < 4; j++) begin
      a_iv = 1'b1;
      a_id = wa(32 + j);
      #1;
      chk("bp_ir", 32'(a_ir), 32'(j < 3));
      step();
    end
    chk("bp_occ", 32'(a_occ), 3);
    chk("bp_od", 32'(a_od), 32'(wa(32)));
    a_id = 16'hdead;
    step();
    chk("bp_hold_od", 32'(a_od), 32'(wa(32)));
    chk("bp_hold_occ", 32'(a_occ), 3);

    // Full with out_ready high: in and out each cycle.
    a_or = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a_iv = 1'b1;
      a_id = wa(35 + j);
      #1;
      chk("full_ir", 32'(a_ir), 1);
      step();
      chk("full_occ", 32'(a_occ), 3);
      chk("full_od", 32'(a_od), 32'(wa(33 + j)));
    end
    a_iv = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("drain_ov", 32'(a_ov), 32'(j < 2));
      if (j < 2) chk("drain_od", 32'(a_od), 32'(wa(36 + j)));
    end

    // Bubble collapse: lone word travels to the end while stalled.
    a_or = 1'b0;
    a_iv = 1'b1;
    a_id = wa(64);
    step();
    a_iv = 1'b0;
    chk("bub_occ1", 32'(a_occ), 1);
    step();
    chk("bub_ov2", 32'(a_ov), 0);
    step();
    chk("bub_ov3", 32'(a_ov), 1);
    chk("bub_od3", 32'(a_od), 32'(wa(64)));
    for (int j = 0; j < 2; j++) begin
      a_iv = 1'b1;
      a_id = wa(65 + j);
      #1;
      chk("bub_ir", 32'(a_ir), 1);
      step();
    end
    a_iv = 1'b0;
    chk("bub_occ", 32'(a_occ), 3);
    chk("bub_od", 32'(a_od), 32'(wa(64)));
    a_or = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bub_drain", 32'(a_od), 32'(wa(64 + j)));
      step();
    end
    chk("bub_empty", 32'(a_ov), 0);

    // Reset with two words in flight.
    a_iv = 1'b1;
    a_id = wa(80);
    step();
    a_id = wa(81);
    step();
    a_iv = 1'b0;
    rst  = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ov", 32'(a_ov), 0);
    chk("mrst_occ", 32'(a_occ), 0);
    chk("mrst_od", 32'(a_od), 0);
    chk("mrst_ir", 32'(a_ir), 1);
    a_iv = 1'b1;
    a_id = wa(90);
    step();
    a_iv = 1'b0;
    step();
    chk("mrst_lat2", 32'(a_ov), 0);
    step();
    chk("mrst_ov3", 32'(a_ov), 1);
    chk("mrst_od3", 32'(a_od), 32'(wa(90)));
    step();
    chk("mrst_gone", 32'(a_ov), 0);

    // Share isolation: random traffic, per-share scoreboard.
    for (int n = 0; n < 300; n++) begin
      b_iv = 1'($urandom_range(0, 1));
      b_id = 12'($urandom);
      b_or = 1'($urandom_range(0, 1));
      #1;
      chk("b_occ", 32'(b_occ), 32'(q.size()));
      if (b_ov && b_or) begin
        if (q.size() == 0) begin
          chk("b_spurious", 32'(b_ov), 0);
        end else begin
          e = q.pop_front();
          chk("b_sh0", 32'(b_od[3:0]), 32'(e[3:0]));
          chk("b_sh1", 32'(b_od[7:4]), 32'(e[7:4]));
          chk("b_sh2", 32'(b_od[11:8]), 32'(e[11:8]));
        end
      end
      if (b_iv && b_ir) q.push_back(b_id);
      step();
    end
    b_iv = 1'b0;
    b_or = 1'b1;
    step();
    step();
    step();
    chk("b_drained", 32'(b_ov), 0);

    // Corner L=1, D=1, W=1.
    c_or = 1'b0;
    c_iv = 1'b1;
    c_id = 1'b1;
    #1;
    chk("c_ir0", 32'(c_ir), 1);
    step();
    chk("c_ov", 32'(c_ov), 1);
    chk("c_od", 32'(c_od), 1);
    chk("c_occ", 32'(c_occ), 1);
    c_id = 1'b0;
    #1;
    chk("c_ir_full", 32'(c_ir), 0);
    step();
    chk("c_hold", 32'(c_od), 1);
    c_or = 1'b1;
    #1;
    chk("c_ir_pass", 32'(c_ir), 1);
    step();
    chk("c_od2", 32'(c_od), 0);
    chk("c_ov2", 32'(c_ov), 1);
    c_iv = 1'b0;
    step();
    chk("c_ov3", 32'(c_ov), 0);
    chk("c_occ3", 32'(c_occ), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
